// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: multi-cycle MSB-first chunked magnitude compare with early exit.
// Define SERIAL_CMP_SIGNED_EN to honour signed_mode (two's-complement compare).
module serial_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             lesser,
  output logic             equal,
  output logic             greater
);
  localparam int n = WIDTH / CHUNK;
  localparam int iw = n > 1 ? $clog2(n) : 1;
  localparam logic [CHUNK-1:0] top_bit = CHUNK'(1) << (CHUNK - 1);
  typedef enum logic {idle, run} state_t;
  state_t state;
  logic [WIDTH-1:0] xr, yr;
  logic [iw-1:0] idx;
  logic [CHUNK-1:0] xc, yc;
  logic flip;
`ifdef SERIAL_CMP_SIGNED_EN
  logic sr;
  assign flip = sr && idx == iw'(n - 1);
`else
  logic unused_sm;
  assign unused_sm = signed_mode;
  assign flip = 1'b0;
`endif
  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign xc = xr[idx*CHUNK +: CHUNK] ^ (flip ? top_bit : '0);
  assign yc = yr[idx*CHUNK +: CHUNK] ^ (flip ? top_bit : '0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= idle;
      xr <= '0;
      yr <= '0;
      idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      lesser <= 1'b0;
      equal <= 1'b0;
      greater <= 1'b0;
`ifdef SERIAL_CMP_SIGNED_EN
      sr <= 1'b0;
`endif
    end else if (state == idle) begin
      done <= 1'b0;
      if (start) begin
        xr <= x;
        yr <= y;
`ifdef SERIAL_CMP_SIGNED_EN
        sr <= signed_mode;
`endif
        idx <= iw'(n - 1);
        busy <= 1'b1;
        lesser <= 1'b0;
        equal <= 1'b0;
        greater <= 1'b0;
        state <= run;
      end
    end else if (xc != yc || idx == '0) begin
      lesser <= xc < yc;
      equal <= xc == yc;
      greater <= xc > yc;
      done <= 1'b1;
      busy <= 1'b0;
      state <= idle;
    end else begin
      idx <= idx - 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: directed and random checks against an arithmetic reference model.
module tb_serial_magnitude_comparator;
  localparam int N = 8;
  localparam int C = 4;
`ifdef SERIAL_CMP_SIGNED_EN
  localparam bit signed_en = 1'b1;
`else
  localparam bit signed_en = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_mode = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic busy, done, lesser, equal, greater;
  int n_chk = 0, n_fail = 0;

  serial_magnitude_comparator #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .signed_mode(signed_mode),
    .busy(busy), .done(done), .lesser(lesser), .equal(equal), .greater(greater)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b, input logic sm);
    if (sm && signed_en)
      return $signed(a) < $signed(b) ? 3'b100 : a == b ? 3'b010 : 3'b001;
    return a < b ? 3'b100 : a == b ? 3'b010 : 3'b001;
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a ^ b;
    for (int p = 31; p >= 0; p--)
      if (d[p]) return N - p / C;
    return N;
  endfunction

  task automatic wait_done(input string tag, input int lat0, input int exp_lat, input logic [2:0] e);
    int lat;
    lat = lat0;
    while (!done && lat < N + 4) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " flags"}, 32'({lesser, equal, greater}), 32'(e));
    chk({tag, " busy at done"}, 32'(busy), 32'd0);
  endtask

  task automatic do_cmp(input logic [31:0] a, input logic [31:0] b, input logic sm, input string tag);
    logic [2:0] e;
    e = model(a, b, sm);
    start = 1'b1; x = a; y = b; signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0; x = $urandom; y = $urandom; signed_mode = 1'($urandom);
    chk({tag, " accept"}, 32'({done, lesser, equal, greater}), 32'd0);
    wait_done(tag, 0, model_lat(a, b), e);
  endtask

  task automatic post_check(input logic [2:0] e, input string tag);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, 32'(done), 32'd0);
    chk({tag, " flags held"}, 32'({lesser, equal, greater}), 32'(e));
  endtask

  initial begin
    logic [31:0] a, b;
    logic sm;
    int nd;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 32'({busy, done, lesser, equal, greater}), 32'd0);
    rst_n = 1'b1;
    do_cmp(32'h12345678, 32'h12345678, 1'b0, "equal");
    post_check(3'b010, "equal");
    do_cmp(32'h80000000, 32'h00000001, 1'b0, "msb unsigned");
    post_check(3'b001, "msb unsigned");
    do_cmp(32'h80000000, 32'h00000001, 1'b1, "msb signed");
    post_check(model(32'h80000000, 32'h00000001, 1'b1), "msb signed");
    do_cmp(32'h000000A0, 32'h000000B0, 1'b0, "late");
    post_check(3'b100, "late");
    start = 1'b1; x = 32'd5; y = 32'd5; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; x = 32'd9; y = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy start", 3, N, 3'b010);
    nd = 0;
    repeat (10) begin
      @(posedge clk); #1;
      nd += int'(done);
    end
    chk("busy start extra done", 32'(nd), 32'd0);
    do_cmp(32'd7, 32'd7, 1'b0, "b2b first");
    do_cmp(32'd3, 32'd2, 1'b0, "b2b second");
    post_check(3'b001, "b2b second");
    a = $urandom;
    start = 1'b1; x = a; y = a; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid reset", 32'({busy, done, lesser, equal, greater}), 32'd0);
    nd = 0;
    repeat (10) begin
      @(posedge clk); #1;
      nd += int'(done);
    end
    chk("mid reset no done", 32'(nd), 32'd0);
    do_cmp(32'h0F0F0F0F, 32'h0F0F1F0F, 1'b0, "after reset");
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0: b = $urandom;
        1: b = a;
        default: b = a ^ (32'd1 << $urandom_range(0, 31));
      endcase
      sm = 1'($urandom);
      do_cmp(a, b, sm, "random");
      if ($urandom_range(0, 1) == 1) post_check(model(a, b, sm), "random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
